// File: rtl/mo_module.sv
// 8-bit accumulator ALU tile: one opcode per enabled strobe against operand B,
// result held in acc with Z/C/N flags on the upper bidirectional pins.
module mo_module (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_ADD = 4'h2, OP_ADC = 4'h3,
        OP_SUB = 4'h4, OP_AND  = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_NOT = 4'h8, OP_SHL  = 4'h9, OP_SHR = 4'hA, OP_ROL = 4'hB,
        OP_ROR = 4'hC, OP_INC  = 4'hD, OP_DEC = 4'hE, OP_CLR = 4'hF
    } op_e;

    logic [7:0] acc, acc_nxt;
    logic       c, c_nxt;
    op_e        op;
    logic       go;
    logic       unused_uio;

    assign op         = op_e'(uio_in[3:0]);
    assign go         = uio_in[4];
    assign unused_uio = &{1'b0, uio_in[7:5]};

    always_comb begin
        acc_nxt = acc;
        c_nxt   = c;
        case (op)
            OP_NOP:  ;
            OP_LOAD: begin acc_nxt = ui_in; c_nxt = 1'b0; end
            OP_ADD:  {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, ui_in};
            OP_ADC:  {c_nxt, acc_nxt} = {1'b0, acc} + {1'b0, ui_in} + {8'd0, c};
            // C reports borrow, taken from the pre-op accumulator
            OP_SUB:  begin acc_nxt = acc - ui_in; c_nxt = (acc < ui_in); end
            OP_AND:  begin acc_nxt = acc & ui_in; c_nxt = 1'b0; end
            OP_OR:   begin acc_nxt = acc | ui_in; c_nxt = 1'b0; end
            OP_XOR:  begin acc_nxt = acc ^ ui_in; c_nxt = 1'b0; end
            OP_NOT:  acc_nxt = ~acc;
            OP_SHL:  begin acc_nxt = {acc[6:0], 1'b0};   c_nxt = acc[7]; end
            OP_SHR:  begin acc_nxt = {1'b0, acc[7:1]};   c_nxt = acc[0]; end
            OP_ROL:  begin acc_nxt = {acc[6:0], acc[7]}; c_nxt = acc[7]; end
            OP_ROR:  begin acc_nxt = {acc[0], acc[7:1]}; c_nxt = acc[0]; end
            OP_INC:  {c_nxt, acc_nxt} = {1'b0, acc} + 9'd1;
            OP_DEC:  begin acc_nxt = acc - 8'd1; c_nxt = (acc == 8'd0); end
            OP_CLR:  begin acc_nxt = 8'd0; c_nxt = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'd0;
            c   <= 1'b0;
        end else if (ena && go) begin
            acc <= acc_nxt;
            c   <= c_nxt;
        end
    end

    assign uo_out  = acc;
    assign uio_out = {acc[7], c, (acc == 8'd0), 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_mo_module.sv
// Bench for mo_module: directed vector table, reset sequences and a
// randomized run checked against an integer-arithmetic model.
module tb_mo_module;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_pass = 0;
    int n_total = 0;

    int m_acc;
    int m_c;

    mo_module dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] b;
        logic       en;
        logic       go;
        logic [7:0] acc;
        logic       c;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    function automatic logic [7:0] flags(input int a, input int cy);
        logic [7:0] f;
        f = 8'h00;
        f[7] = (a >= 128);
        f[6] = (cy != 0);
        f[5] = (a == 0);
        return f;
    endfunction

    // Reference behaviour expressed as plain integer arithmetic
    task automatic model_step(input int op, input int b, input bit en, input bit go);
        int t;
        if (!(en && go)) return;
        case (op)
            1:  begin m_acc = b; m_c = 0; end
            2:  begin t = m_acc + b;        m_acc = t % 256; m_c = (t > 255); end
            3:  begin t = m_acc + b + m_c;  m_acc = t % 256; m_c = (t > 255); end
            4:  begin m_c = (m_acc < b); m_acc = (m_acc - b + 256) % 256; end
            5:  begin m_acc = m_acc & b; m_c = 0; end
            6:  begin m_acc = m_acc | b; m_c = 0; end
            7:  begin m_acc = m_acc ^ b; m_c = 0; end
            8:  m_acc = 255 - m_acc;
            9:  begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
            10: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
            11: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256 + m_acc / 128; end
            12: begin m_c = m_acc % 2; m_acc = m_acc / 2 + (m_acc % 2) * 128; end
            13: begin t = m_acc + 1; m_acc = t % 256; m_c = (t > 255); end
            14: begin m_c = (m_acc == 0); m_acc = (m_acc + 255) % 256; end
            15: begin m_acc = 0; m_c = 0; end
            default: ;
        endcase
    endtask

    // Drive one cycle's inputs, then sample just after the rising edge
    task automatic drive(input logic [3:0] op, input logic [7:0] b, input logic en, input logic go);
        logic [2:0] junk;
        junk   = 3'($urandom_range(0, 7));
        uio_in = {junk, go, op};
        ui_in  = b;
        ena    = en;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // LOAD/ADD/ADC chain
        vecs.push_back('{4'h1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{4'h2, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{4'h3, 8'h10, 1'b1, 1'b1, 8'h11, 1'b0});
        // SUB/DEC borrow
        vecs.push_back('{4'h1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0});
        vecs.push_back('{4'h4, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b1});
        vecs.push_back('{4'h1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{4'hE, 8'h33, 1'b1, 1'b1, 8'hFF, 1'b1});
        // shifts and rotates from 81
        vecs.push_back('{4'h1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0});
        vecs.push_back('{4'h9, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{4'h1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0});
        vecs.push_back('{4'hC, 8'h00, 1'b1, 1'b1, 8'hC0, 1'b1});
        vecs.push_back('{4'h1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0});
        vecs.push_back('{4'hB, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1});
        vecs.push_back('{4'h1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0});
        vecs.push_back('{4'hA, 8'h00, 1'b1, 1'b1, 8'h40, 1'b1});
        // logic ops and hold
        vecs.push_back('{4'h1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0});
        vecs.push_back('{4'h5, 8'h0F, 1'b1, 1'b1, 8'h0C, 1'b0});
        vecs.push_back('{4'h6, 8'hF0, 1'b1, 1'b1, 8'hFC, 1'b0});
        vecs.push_back('{4'h7, 8'hFF, 1'b1, 1'b1, 8'h03, 1'b0});
        vecs.push_back('{4'h8, 8'h00, 1'b1, 1'b1, 8'hFC, 1'b0});
        vecs.push_back('{4'hF, 8'h00, 1'b0, 1'b1, 8'hFC, 1'b0});
        vecs.push_back('{4'hF, 8'h00, 1'b1, 1'b0, 8'hFC, 1'b0});
        vecs.push_back('{4'h0, 8'h55, 1'b1, 1'b1, 8'hFC, 1'b0});
        // equal-operand SUB, INC wrap, NOT keeps C, CLR
        vecs.push_back('{4'h1, 8'h42, 1'b1, 1'b1, 8'h42, 1'b0});
        vecs.push_back('{4'h4, 8'h42, 1'b1, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{4'h1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{4'hD, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{4'h8, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{4'hF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0});

        // Reset with arbitrary inputs, including an active strobe
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hA7;
        uio_in = 8'h1D;
        #3;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h20);
        chk("rst_uio_oe", uio_oe, 8'hE0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_hold_uo", uo_out, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(4'(i), 8'($urandom), 1'b1, 1'b0);
            chk("idle_uo", uo_out, 8'h00);
            chk("idle_uio_out", uio_out, 8'h20);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].b, vecs[i].en, vecs[i].go);
            chk($sformatf("vec%0d_acc", i), uo_out, vecs[i].acc);
            chk($sformatf("vec%0d_flags", i), uio_out, flags(int'(vecs[i].acc), int'(vecs[i].c)));
        end

        // Op strobed on the first edge after reset release executes
        #2 rst_n = 1'b0;
        #1 chk("rst2_uo", uo_out, 8'h00);
        rst_n = 1'b1;
        drive(4'h1, 8'h5A, 1'b1, 1'b1);
        chk("first_edge_load", uo_out, 8'h5A);
        m_acc = 8'h5A;
        m_c   = 0;

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [7:0] b;
            logic en, go;
            op = 4'($urandom_range(0, 15));
            b  = 8'($urandom);
            en = ($urandom_range(0, 7) != 0);
            go = ($urandom_range(0, 3) != 0);
            drive(op, b, en, go);
            model_step(int'(op), int'(b), en, go);
            chk("rand_acc", uo_out, 8'(m_acc));
            chk("rand_flags", uio_out, flags(m_acc, m_c));
            if (i % 50 == 0) chk("rand_oe", uio_oe, 8'hE0);
        end

        // Reset mid-stream while INC re-executes every cycle
        drive(4'h1, 8'h10, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(4'hD, 8'h00, 1'b1, 1'b1);
            chk("inc_stream", uo_out, 8'(8'h11 + i));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_uio_out", uio_out, 8'h20);
        chk("midrst_uio_oe", uio_oe, 8'hE0);
        @(posedge clk); #1;
        chk("midrst_hold", uo_out, 8'h00);
        rst_n = 1'b1;
        drive(4'hD, 8'h00, 1'b1, 1'b1);
        chk("post_rst_inc", uo_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
